// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the execute-stage units.
// Op codes, FSM encodings and default multiply/divide parameters.
package muldiv_unit_pkg;

    localparam int MULDIV_WIDTH      = 32;
    localparam int MULDIV_MUL_CYCLES = 5;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-divide iteration on unsigned magnitudes.
// Remainder stays below the divisor, so WIDTH bits always suffice.
module muldiv_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             din,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    assign shifted  = {rem, din};
    assign qbit     = shifted >= {1'b0, divisor};
    assign diff     = shifted[WIDTH-1:0] - divisor;
    assign rem_next = qbit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply-divide unit.
// Multiply is a held combinational product; divide is restoring, one bit per cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH      = MULDIV_WIDTH,
    parameter int MUL_CYCLES = MULDIV_MUL_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CMAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0]    ONE     = CW'(1);
    localparam logic [WIDTH-1:0] MOSTNEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL1    = '1;

    muldiv_state_t state, nstate;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa, opb, dvs, rem, quo;
    logic               msgn, aneg, qneg, bzero, ovf;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;
    logic [2*WIDTH-1:0] ea, eb, prod;
    logic [WIDTH-1:0]   q_fix, r_fix;
    logic               dsgn, sa, sb;

    assign busy = (state != IDLE);

    // Sign-extend to 2*WIDTH so the low half of a plain product is exact
    assign ea   = {{WIDTH{msgn & opa[WIDTH-1]}}, opa};
    assign eb   = {{WIDTH{msgn & opb[WIDTH-1]}}, opb};
    assign prod = ea * eb;

    assign dsgn = (op == OP_DIV);
    assign sa   = dsgn & SrcA[WIDTH-1];
    assign sb   = dsgn & SrcB[WIDTH-1];

    assign q_fix = qneg ? -quo : quo;
    assign r_fix = aneg ? -rem : rem;

    muldiv_divstep #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .divisor  (dvs),
        .din      (quo[WIDTH-1]),
        .rem_next (step_rem),
        .qbit     (step_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (start) begin
                if (op == OP_MULT || op == OP_MULTU)
                    nstate = MUL;
                else if (op == OP_DIV || op == OP_DIVU)
                    nstate = DIV;
            end
            MUL: if (cnt == '0) nstate = IDLE;
            DIV: if (cnt == '0) nstate = FIX;
            FIX: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            dvs   <= '0;
            rem   <= '0;
            quo   <= '0;
            msgn  <= 1'b0;
            aneg  <= 1'b0;
            qneg  <= 1'b0;
            bzero <= 1'b0;
            ovf   <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    unique case (op)
                        OP_MTHI: HI <= SrcA;
                        OP_MTLO: LO <= SrcA;
                        OP_MULT, OP_MULTU: begin
                            opa  <= SrcA;
                            opb  <= SrcB;
                            msgn <= (op == OP_MULT);
                            cnt  <= CW'(MUL_CYCLES - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            opa   <= SrcA;
                            quo   <= sa ? -SrcA : SrcA;
                            dvs   <= sb ? -SrcB : SrcB;
                            rem   <= '0;
                            aneg  <= sa;
                            qneg  <= sa ^ sb;
                            bzero <= (SrcB == '0);
                            ovf   <= dsgn && SrcA == MOSTNEG
                                     && SrcB == ALL1;
                            cnt   <= CW'(WIDTH - 1);
                        end
                        default: ;
                    endcase
                end
                MUL: begin
                    if (cnt == '0) {HI, LO} <= prod;
                    else           cnt <= cnt - ONE;
                end
                DIV: begin
                    rem <= step_rem;
                    quo <= {quo[WIDTH-2:0], step_q};
                    if (cnt != '0) cnt <= cnt - ONE;
                end
                FIX: begin
                    if (bzero) begin
                        LO <= ALL1;
                        HI <= opa;
                    end else if (ovf) begin
                        LO <= MOSTNEG;
                        HI <= '0;
                    end else begin
                        LO <= q_fix;
                        HI <= r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32, MUL_CYCLES=5.
// Expected HI/LO and busy lengths are hand-computed constants.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        busy;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32), .MUL_CYCLES(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int ecyc);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (n == 2) begin
                check({tag, " hold HI"}, HI, mhi);
                check({tag, " hold LO"}, LO, mlo);
            end
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 32'(n), 32'(ecyc));
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int ecyc,
                       input logic [31:0] ehi, input logic [31:0] elo);
        @(negedge clk);
        op = o; SrcA = a; SrcB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(tag, ecyc);
        check({tag, " HI"}, HI, ehi);
        check({tag, " LO"}, LO, elo);
        mhi = ehi;
        mlo = elo;
    endtask

    initial begin
        #3;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run("multu max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
            32'hFFFFFFFE, 32'h00000001);
        run("mult -3x7", 3'd0, 32'hFFFFFFFD, 32'd7, 5,
            32'hFFFFFFFF, 32'hFFFFFFEB);
        run("mult -4x-5", 3'd0, 32'hFFFFFFFC, 32'hFFFFFFFB, 5,
            32'd0, 32'd20);
        run("mthi", 3'd4, 32'h12345678, 32'd0, 0,
            32'h12345678, 32'd20);
        run("mtlo", 3'd5, 32'hCAFEF00D, 32'd0, 0,
            32'h12345678, 32'hCAFEF00D);
        run("nop6", 3'd6, 32'h11111111, 32'h2, 0,
            32'h12345678, 32'hCAFEF00D);
        run("div -7/2", 3'd2, 32'hFFFFFFF9, 32'd2, 33,
            32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div 7/-2", 3'd2, 32'd7, 32'hFFFFFFFE, 33,
            32'd1, 32'hFFFFFFFD);
        run("divu 100/7", 3'd3, 32'd100, 32'd7, 33,
            32'd2, 32'd14);
        run("divu x/0", 3'd3, 32'h55, 32'd0, 33,
            32'h55, 32'hFFFFFFFF);
        run("div -5/0", 3'd2, 32'hFFFFFFFB, 32'd0, 33,
            32'hFFFFFFFB, 32'hFFFFFFFF);
        run("div ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 33,
            32'd0, 32'h80000000);
        run("divu big", 3'd3, 32'hFFFFFFFF, 32'h10, 33,
            32'hF, 32'h0FFFFFFF);

        // MTLO pulsed mid-divide must be dropped
        @(negedge clk);
        op = 3'd2; SrcA = 32'hFFFFFFF9; SrcB = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        op = 3'd5; SrcA = 32'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignored mtlo", 29);
        check("ignored mtlo LO", LO, 32'hFFFFFFFD);
        check("ignored mtlo HI", HI, 32'hFFFFFFFF);
        mhi = 32'hFFFFFFFF;
        mlo = 32'hFFFFFFFD;

        // Asynchronous reset ten cycles into a divide
        @(negedge clk);
        op = 3'd2; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst HI", HI, 32'd0);
        check("async rst LO", LO, 32'd0);
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        op = 3'd1; SrcA = 32'd2; SrcB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("post rst multu", 5);
        check("post rst HI", HI, 32'd0);
        check("post rst LO", LO, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and HI/LO register width, even, >= 8.
REQ-002 Parameter MUL_CYCLES, default 5: multiply busy duration in cycles, >= 1.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle operation request.
REQ-007 op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
REQ-008 SrcA  in  WIDTH  multiplicand / dividend / move source.
REQ-009 SrcB  in  WIDTH  multiplier / divisor.
REQ-010 busy  out  1  high while an operation is in flight.
REQ-011 HI  out  WIDTH  HI register: product upper half or remainder.
REQ-012 LO  out  WIDTH  LO register: product lower half or quotient.

Function
REQ-013 FSM states: IDLE, MUL, DIV, FIX; reset state is IDLE.
REQ-014 start is sampled only in IDLE; start while busy=1 is ignored, with no effect on state, operands or HI/LO.
REQ-015 Accepted MTHI/MTLO writes SrcA into HI/LO at the accepting edge; busy stays 0; FSM stays IDLE.
REQ-016 Accepted MULT/MULTU latches operands and enters MUL; busy is high for exactly MUL_CYCLES cycles after the accepting edge; {HI,LO} takes the 2*WIDTH-bit product at the edge where busy falls.
REQ-017 MULT treats operands as two's complement; MULTU treats them as unsigned.
REQ-018 Accepted DIV/DIVU latches operand magnitudes and signs and enters DIV; DIV runs WIDTH restoring iterations, one quotient bit per cycle, then FIX for one cycle; busy is high for WIDTH+1 cycles; HI/LO are written at the FIX exit edge.
REQ-019 Signed divide truncates toward zero: quotient sign = sign(A) xor sign(B); remainder takes the sign of the dividend.
REQ-020 Divide by zero (either signedness): LO = all ones, HI = SrcA unchanged; full WIDTH+1 latency retained.
REQ-021 Signed overflow (most-negative / -1): LO = most-negative value, HI = 0.
REQ-022 HI/LO hold their previous values throughout busy and change only at the completion edge.
REQ-023 busy is registered, driven directly from FSM state != IDLE; a new start is accepted on the first cycle busy reads 0.
REQ-024 Op codes 6 and 7 with start are accepted no-ops: no state change.

Reset
REQ-025 Reset assertion, including mid-operation, asynchronously forces IDLE, busy = 0, HI = 0, LO = 0, and clears the cycle counter and partial remainder/quotient.
REQ-026 After reset deassertion, the first rising edge accepts start normally.

Structure
REQ-027 Op-code constants, FSM state encodings and the default parameter values live in the shared define file, alongside the ALU control constants.
REQ-028 One sub-module, muldiv_divstep: one combinational restoring-divide iteration (partial remainder, divisor, next dividend bit in; new remainder and quotient bit out).
REQ-029 The multiply is a single combinational product registered through a MUL_CYCLES countdown; no multiplier pipeline stages are required.

Verification (WIDTH=32, MUL_CYCLES=5)
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 5 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MTHI 0x12345678 -> HI=0x12345678 at the next edge, busy=0.
REQ-032 DIV -7 / 2 -> busy for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 -> LO=14, HI=2.
REQ-033 DIVU 0x55 / 0 -> LO=0xFFFFFFFF, HI=0x55; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 start with MTLO 0xAA issued while a DIV is busy -> ignored; LO equals the DIV quotient afterwards.
REQ-035 Reset asserted 10 cycles into a DIV -> busy, HI and LO read 0 immediately (before the next clock edge); a MULTU 2 x 3 issued after deassertion yields LO=6.
